// File: rtl/m68k_bus_pkg.sv
// Shared types and constants for the 68000-style bus master: FSM states,
// byte-enable encodings and default parameter values.
package m68k_bus_pkg;

  localparam int unsigned DEFAULT_ADDR_W      = 23;
  localparam int unsigned DEFAULT_TIMEOUT_CYC = 255;
  localparam int unsigned TMO_CNT_W           = 8;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WAIT,
    DONE,
    RECOV
  } bus_state_e;

  localparam logic [1:0] BE_NONE  = 2'b00;
  localparam logic [1:0] BE_UPPER = 2'b10;
  localparam logic [1:0] BE_LOWER = 2'b01;
  localparam logic [1:0] BE_WORD  = 2'b11;

endpackage

// File: rtl/bus_timeout_ctr.sv
// Saturating cycle counter that flags an overlong WAIT/RECOV phase.
// Only instantiated when BUS_TIMEOUT_EN is defined.
module bus_timeout_ctr
  import m68k_bus_pkg::*;
#(
  parameter int unsigned LIMIT = DEFAULT_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired_c
);

  localparam logic [TMO_CNT_W-1:0] CNT_MAX = '1;
  // Count value seen during the LIMIT-th enabled cycle after a clear.
  localparam logic [TMO_CNT_W-1:0] LAST    = TMO_CNT_W'(LIMIT - 1);

  logic [TMO_CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (enable && (cnt != CNT_MAX)) begin
      cnt <= cnt + TMO_CNT_W'(1);
    end
  end

  assign expired_c = (cnt >= LAST);

endmodule

// File: rtl/m68k_bus_master.sv
// 68000-style asynchronous bus initiator: runs one word/byte cycle per local
// request and waits for DTACK. Optional bus timeout via BUS_TIMEOUT_EN.
module m68k_bus_master
  import m68k_bus_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEFAULT_ADDR_W,
  parameter int unsigned TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  output logic              ready,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_be,
  input  logic [15:0]       req_wdata,
  output logic              done,
  output logic              err,
  output logic [15:0]       rdata,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [15:0]       bus_dout,
  output logic              bus_doe,
  input  logic [15:0]       bus_din,
  output logic              as_n,
  output logic              uds_n,
  output logic              lds_n,
  output logic              rw,
  input  logic              dtack_n
);

  if ((TIMEOUT_CYC < 4) || (TIMEOUT_CYC > 256)) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be in the range 4..256");
  end

  bus_state_e state;
  logic       lat_rw;
  logic [1:0] lat_be;
  logic       dtack_m;
  logic       dtack_s;
  logic       timeout_c;

  // dtack_n comes from an unrelated responder; synchronise before use.
  always_ff @(posedge clk) begin
    if (reset) begin
      dtack_m <= 1'b1;
      dtack_s <= 1'b1;
    end else begin
      dtack_m <= dtack_n;
      dtack_s <= dtack_m;
    end
  end

`ifdef BUS_TIMEOUT_EN
  logic tmo_run_c;

  // Counter runs only in WAIT/RECOV, so it is always zero on entry to either.
  assign tmo_run_c = (state == WAIT) || (state == RECOV);

  bus_timeout_ctr #(
    .LIMIT (TIMEOUT_CYC)
  ) u_timeout (
    .clk       (clk),
    .reset     (reset),
    .clear     (~tmo_run_c),
    .enable    (tmo_run_c),
    .expired_c (timeout_c)
  );
`else
  assign timeout_c = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ready    <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
      rdata    <= '0;
      bus_addr <= '0;
      bus_dout <= '0;
      bus_doe  <= 1'b0;
      as_n     <= 1'b1;
      uds_n    <= 1'b1;
      lds_n    <= 1'b1;
      rw       <= 1'b1;
      lat_rw   <= 1'b1;
      lat_be   <= BE_NONE;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (req && ready) begin
            lat_rw   <= req_rw;
            lat_be   <= req_be;
            bus_addr <= req_addr;
            bus_dout <= req_wdata;
            ready    <= 1'b0;
            if (req_be == BE_NONE) begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state   <= ADDR;
              rw      <= req_rw;
              bus_doe <= ~req_rw;
            end
          end
        end
        ADDR: begin
          state <= WAIT;
          as_n  <= 1'b0;
          uds_n <= ~lat_be[1];
          lds_n <= ~lat_be[0];
        end
        WAIT: begin
          // Acknowledge takes priority over a coincident timeout.
          if (!dtack_s) begin
            state <= DONE;
            done  <= 1'b1;
            as_n  <= 1'b1;
            uds_n <= 1'b1;
            lds_n <= 1'b1;
            if (lat_rw) begin
              rdata <= bus_din;
            end
          end else if (timeout_c) begin
            state <= DONE;
            done  <= 1'b1;
            err   <= 1'b1;
            as_n  <= 1'b1;
            uds_n <= 1'b1;
            lds_n <= 1'b1;
          end
        end
        DONE: begin
          state   <= RECOV;
          bus_doe <= 1'b0;
          rw      <= 1'b1;
        end
        RECOV: begin
          if (dtack_s || timeout_c) begin
            state <= IDLE;
            ready <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          ready   <= 1'b1;
          bus_doe <= 1'b0;
          as_n    <= 1'b1;
          uds_n   <= 1'b1;
          lds_n   <= 1'b1;
          rw      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_m68k_bus_master.sv
// Scoreboard bench for m68k_bus_master: random requests against a behavioural
// responder, with completion and bus-phase expectations queued per request.
module tb_m68k_bus_master;
  import m68k_bus_pkg::*;

  localparam int unsigned AW  = 23;
  localparam int unsigned TMO = 20;

  logic          clk = 1'b0;
  logic          reset;
  logic          req;
  logic          ready;
  logic          req_rw;
  logic [AW-1:0] req_addr;
  logic [1:0]    req_be;
  logic [15:0]   req_wdata;
  logic          done;
  logic          err;
  logic [15:0]   rdata;
  logic [AW-1:0] bus_addr;
  logic [15:0]   bus_dout;
  logic          bus_doe;
  logic [15:0]   bus_din;
  logic          as_n;
  logic          uds_n;
  logic          lds_n;
  logic          rw;
  logic          dtack_n;

  m68k_bus_master #(
    .ADDR_W      (AW),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .ready     (ready),
    .req_rw    (req_rw),
    .req_addr  (req_addr),
    .req_be    (req_be),
    .req_wdata (req_wdata),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .bus_addr  (bus_addr),
    .bus_dout  (bus_dout),
    .bus_doe   (bus_doe),
    .bus_din   (bus_din),
    .as_n      (as_n),
    .uds_n     (uds_n),
    .lds_n     (lds_n),
    .rw        (rw),
    .dtack_n   (dtack_n)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req_v);
    end
  endtask

  // Responder: pulls dtack_n low cur_delay cycles after as_n falls, releases with as_n.
  int wcnt      = 0;
  int cur_delay = 0;
  bit dtack_hold = 1'b0;
  bit dtack_none = 1'b0;

  always @(posedge clk) wcnt <= (as_n === 1'b0) ? wcnt + 1 : 0;

  assign dtack_n = dtack_hold ? 1'b0 :
                   dtack_none ? 1'b1 :
                   !((as_n === 1'b0) && (wcnt >= cur_delay));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        err;
    logic [15:0] rdata;
    int          cyc;
  } exp_t;

  typedef struct {
    logic          uds_n;
    logic          lds_n;
    logic          rw;
    logic          doe;
    logic [AW-1:0] addr;
    logic [15:0]   dout;
  } bus_t;

  exp_t        exp_q[$];
  bus_t        bus_q[$];
  exp_t        mon_e;
  bus_t        cur_bus;
  bit          have_bus = 1'b0;
  logic        as_prev  = 1'b1;
  logic [15:0] model_rdata = 16'h0;

  // Monitor: completion and bus-phase checks against queued expectations.
  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      if (done === 1'b1) begin
        check("done_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("err", err, mon_e.err);
          check("rdata", rdata, mon_e.rdata);
          if (mon_e.cyc >= 0) check("done_cycle", cyc, mon_e.cyc);
        end
        check("strobes_at_done", {as_n, uds_n, lds_n}, 3'b111);
        have_bus = 1'b0;
      end
      if ((as_n === 1'b0) && (as_prev === 1'b1)) begin
        check("as_expected", 32'(bus_q.size() != 0), 1);
        if (bus_q.size() != 0) begin
          cur_bus  = bus_q.pop_front();
          have_bus = 1'b1;
        end else begin
          have_bus = 1'b0;
        end
      end
      if ((as_n === 1'b0) && have_bus) begin
        check("uds_n", uds_n, cur_bus.uds_n);
        check("lds_n", lds_n, cur_bus.lds_n);
        check("rw", rw, cur_bus.rw);
        check("bus_doe", bus_doe, cur_bus.doe);
        check("bus_addr", bus_addr, cur_bus.addr);
        if (!cur_bus.rw) check("bus_dout", bus_dout, cur_bus.dout);
      end
    end
    as_prev = as_n;
  end

  function automatic int exp_latency(input logic [1:0] be, input int d, input bit noack);
    if (be == BE_NONE) return 0;
    if (noack) return 1 + TMO;
    return 4 + d;
  endfunction

  // mode: 0 = normal, 1 = no acknowledge (timeout), 2 = latency not checked.
  task automatic do_req(input logic rw_i, input logic [AW-1:0] a, input logic [1:0] be,
                        input logic [15:0] wd, input logic [15:0] din, input int d,
                        input int mode);
    exp_t e;
    bus_t b;
    int   n;
    n = 0;
    while (ready !== 1'b1) begin
      if (n >= 600) begin
        check("ready_wait", ready, 1);
        return;
      end
      // Junk requests while busy must be ignored.
      req       = ($urandom_range(0, 3) == 0);
      req_rw    = 1'($urandom);
      req_addr  = AW'($urandom);
      req_be    = 2'($urandom);
      req_wdata = 16'($urandom);
      @(negedge clk);
      n++;
    end
    req        = 1'b1;
    req_rw     = rw_i;
    req_addr   = a;
    req_be     = be;
    req_wdata  = wd;
    bus_din    = din;
    cur_delay  = d;
    dtack_none = (mode == 1);
    e.err = (be == BE_NONE) || (mode == 1);
    if (!e.err && rw_i) model_rdata = din;
    e.rdata = model_rdata;
    e.cyc   = (mode == 2) ? -1 : cyc + 1 + exp_latency(be, d, mode == 1);
    exp_q.push_back(e);
    if (be != BE_NONE) begin
      b.uds_n = ~be[1];
      b.lds_n = ~be[0];
      b.rw    = rw_i;
      b.doe   = ~rw_i;
      b.addr  = a;
      b.dout  = wd;
      bus_q.push_back(b);
    end
    @(negedge clk);
    req = 1'b0;
    check("ready_low_after_accept", ready, 0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0) && (n < 3000)) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int n;
    reset     = 1'b1;
    req       = 1'b0;
    req_rw    = 1'b1;
    req_addr  = '0;
    req_be    = BE_NONE;
    req_wdata = '0;
    bus_din   = '0;
    repeat (3) @(negedge clk);

    check("rst_ready", ready, 1);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_rdata", rdata, 0);
    check("rst_strobes", {as_n, uds_n, lds_n}, 3'b111);
    check("rst_rw", rw, 1);
    check("rst_doe", bus_doe, 0);
    check("rst_addr", bus_addr, 0);
    check("rst_dout", bus_dout, 0);
    reset = 1'b0;
    @(negedge clk);

    do_req(1'b1, 23'h000100, BE_WORD,  16'h0000, 16'hBEEF, 0, 0);
    do_req(1'b0, 23'h001234, BE_UPPER, 16'h12AB, 16'h0000, 0, 0);
    do_req(1'b1, 23'h0ABCDE, BE_LOWER, 16'h0000, 16'h1357, 5, 0);
    do_req(1'b1, 23'h000200, BE_NONE,  16'h0000, 16'hFFFF, 0, 0);
    do_req(1'b0, 23'h7FFFFF, BE_WORD,  16'hA55A, 16'h0000, 5, 0);

    for (int i = 0; i < 60; i++) begin
      do_req(1'($urandom), AW'($urandom), 2'($urandom), 16'($urandom), 16'($urandom),
             int'($urandom_range(0, 6)), 0);
    end

`ifdef BUS_TIMEOUT_EN
    do_req(1'b1, 23'h3FFFFF, BE_WORD, 16'h0000, 16'hDEAD, 0, 1);
    do_req(1'b1, 23'h000010, BE_WORD, 16'h0000, 16'h0F0F, 1, 0);
`endif
    drain();

    // Reset in the middle of a slow cycle.
    do_req(1'b1, 23'h000300, BE_WORD, 16'h0000, 16'hCAFE, 30, 2);
    n = 0;
    while ((as_n !== 1'b0) && (n < 20)) begin
      @(negedge clk);
      n++;
    end
    check("as_before_reset", as_n, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    bus_q.delete();
    have_bus = 1'b0;
    @(negedge clk);
    check("midrst_strobes", {as_n, uds_n, lds_n}, 3'b111);
    check("midrst_ready", ready, 1);
    check("midrst_done", done, 0);
    reset       = 1'b0;
    model_rdata = 16'h0;
    repeat (8) @(negedge clk);
    check("rdata_after_reset", rdata, 0);

    // Responder still holding dtack: cycle stalls in recovery until released.
    dtack_hold = 1'b1;
    repeat (4) @(negedge clk);
    do_req(1'b1, 23'h000400, BE_LOWER, 16'h0000, 16'h5A5A, 0, 2);
    drain();
    repeat (10) @(negedge clk);
    check("stall_in_recov", ready, 0);
    dtack_hold = 1'b0;
    n = 0;
    while ((ready !== 1'b1) && (n < 10)) begin
      @(negedge clk);
      n++;
    end
    check("ready_after_release", ready, 1);

    do_req(1'b0, 23'h000500, BE_WORD, 16'h4321, 16'h0000, 2, 0);
    do_req(1'b1, 23'h000600, BE_UPPER, 16'h0000, 16'h8421, 0, 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
